// File: rtl/controle_posicionamento.sv
// Placement-phase sequencer: walks both players through the fixed fleet,
// latching coordinates on confirm and handshaking with the piece validator.
module controle_posicionamento #(
    parameter int unsigned NUM_NAVIOS = 11,
    parameter int unsigned TIMEOUT    = 64,
    parameter int unsigned RELEASE    = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       confirma,
    input  logic [3:0] x_in,
    input  logic [3:0] y_in,
    input  logic       direcao_in,
    input  logic [2:0] orientacao_in,
    input  logic       wrep1,
    input  logic       wrep2,
    input  logic       conflito_borda,
    input  logic       conflito_memoria,
    output logic       val_enable,
    output logic [2:0] tipo,
    output logic       direcao,
    output logic [2:0] orientacao,
    output logic [3:0] x1,
    output logic [3:0] y1,
    output logic       jogador,
    output logic [3:0] navio_idx,
    output logic       erro,
    output logic       erro_timeout,
    output logic       concluido,
    output logic [2:0] estado
);

    typedef enum logic [2:0] {
        OCIOSO, ESPERA, AGUARDA, ACEITA, REJEITA, PAUSA, FIM
    } estado_t;

    localparam logic [6:0] TO_LAST  = 7'(TIMEOUT - 1);
    localparam logic [6:0] REL_LAST = 7'(RELEASE - 1);
    localparam logic [3:0] IDX_LAST = 4'(NUM_NAVIOS - 1);

    estado_t    state_q, state_d;
    logic       conf_q;
    logic [6:0] cnt_q, cnt_d;
    logic [3:0] x1_q, x1_d, y1_q, y1_d;
    logic       dir_q, dir_d;
    logic [2:0] ori_q, ori_d;
    logic       jog_q, jog_d;
    logic [3:0] idx_q, idx_d;
    logic       erro_q, erro_d;
    logic       erro_to_q, erro_to_d;
    logic       press;
    logic       strobe;

    assign press  = confirma & ~conf_q;
    assign strobe = jog_q ? wrep2 : wrep1;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        x1_d      = x1_q;
        y1_d      = y1_q;
        dir_d     = dir_q;
        ori_d     = ori_q;
        jog_d     = jog_q;
        idx_d     = idx_q;
        erro_d    = erro_q;
        erro_to_d = erro_to_q;
        case (state_q)
            OCIOSO: begin
                if (start) begin
                    state_d = ESPERA;
                    jog_d   = 1'b0;
                    idx_d   = '0;
                end
            end
            ESPERA: begin
                if (press) begin
                    x1_d      = x_in;
                    y1_d      = y_in;
                    dir_d     = direcao_in;
                    ori_d     = orientacao_in;
                    erro_d    = 1'b0;
                    erro_to_d = 1'b0;
                    cnt_d     = '0;
                    state_d   = AGUARDA;
                end
            end
            AGUARDA: begin
                // Own-player strobe wins over a simultaneous conflict
                cnt_d = cnt_q + 7'd1;
                if (strobe) begin
                    state_d = ACEITA;
                end else if (conflito_borda || conflito_memoria) begin
                    erro_d  = 1'b1;
                    state_d = REJEITA;
                end else if (cnt_q == TO_LAST) begin
                    erro_to_d = 1'b1;
                    state_d   = REJEITA;
                end
            end
            ACEITA: begin
                cnt_d = '0;
                if (idx_q < IDX_LAST) begin
                    idx_d   = idx_q + 4'd1;
                    state_d = PAUSA;
                end else if (!jog_q) begin
                    jog_d   = 1'b1;
                    idx_d   = '0;
                    state_d = PAUSA;
                end else begin
                    state_d = FIM;
                end
            end
            REJEITA: begin
                cnt_d   = '0;
                state_d = PAUSA;
            end
            PAUSA: begin
                // Holds the enable low so the validator sees a fresh rising edge
                if (cnt_q == REL_LAST) state_d = ESPERA;
                else                   cnt_d   = cnt_q + 7'd1;
            end
            FIM:     state_d = FIM;
            default: state_d = OCIOSO;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= OCIOSO;
            conf_q    <= 1'b0;
            cnt_q     <= '0;
            x1_q      <= '0;
            y1_q      <= '0;
            dir_q     <= 1'b0;
            ori_q     <= '0;
            jog_q     <= 1'b0;
            idx_q     <= '0;
            erro_q    <= 1'b0;
            erro_to_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            conf_q    <= confirma;
            cnt_q     <= cnt_d;
            x1_q      <= x1_d;
            y1_q      <= y1_d;
            dir_q     <= dir_d;
            ori_q     <= ori_d;
            jog_q     <= jog_d;
            idx_q     <= idx_d;
            erro_q    <= erro_d;
            erro_to_q <= erro_to_d;
        end
    end

    always_comb begin
        case (idx_q)
            4'd0:                 tipo = 3'd0;
            4'd1, 4'd2:           tipo = 3'd1;
            4'd3, 4'd4:           tipo = 3'd2;
            4'd5, 4'd6, 4'd7:     tipo = 3'd3;
            default:              tipo = 3'd4;
        endcase
    end

    always_comb begin
        case (state_q)
            OCIOSO:           estado = 3'd0;
            ESPERA:           estado = 3'd1;
            AGUARDA:          estado = 3'd2;
            ACEITA:           estado = 3'd3;
            REJEITA, PAUSA:   estado = 3'd4;
            FIM:              estado = 3'd5;
            default:          estado = 3'd0;
        endcase
    end

    assign val_enable   = (state_q == AGUARDA);
    assign concluido    = (state_q == FIM);
    assign x1           = x1_q;
    assign y1           = y1_q;
    assign direcao      = dir_q;
    assign orientacao   = ori_q;
    assign jogador      = jog_q;
    assign navio_idx    = idx_q;
    assign erro         = erro_q;
    assign erro_timeout = erro_to_q;

endmodule

// File: tb/tb_controle_posicionamento.sv
// Scoreboard bench for the placement sequencer: each press queues the
// expected latched values, popped when val_enable rises.
module tb_controle_posicionamento;

    logic       clk, rst_n, start, confirma;
    logic [3:0] x_in, y_in;
    logic       direcao_in;
    logic [2:0] orientacao_in;
    logic       wrep1, wrep2, conflito_borda, conflito_memoria;
    logic       val_enable, direcao, jogador, erro, erro_timeout, concluido;
    logic [2:0] tipo, orientacao, estado;
    logic [3:0] x1, y1, navio_idx;

    controle_posicionamento #(.NUM_NAVIOS(11), .TIMEOUT(64), .RELEASE(2)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .confirma(confirma),
        .x_in(x_in), .y_in(y_in), .direcao_in(direcao_in), .orientacao_in(orientacao_in),
        .wrep1(wrep1), .wrep2(wrep2), .conflito_borda(conflito_borda),
        .conflito_memoria(conflito_memoria), .val_enable(val_enable), .tipo(tipo),
        .direcao(direcao), .orientacao(orientacao), .x1(x1), .y1(y1),
        .jogador(jogador), .navio_idx(navio_idx), .erro(erro),
        .erro_timeout(erro_timeout), .concluido(concluido), .estado(estado)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] x, y;
        logic       d;
        logic [2:0] o, t;
        logic       j;
        logic [3:0] idx;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fails  = 0;
    int   m_idx, m_jog, m_done;
    logic prev_ve = 1'b0;

    task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [2:0] tipo_of(input int idx);
        if (idx == 0)     return 3'd0;
        else if (idx < 3) return 3'd1;
        else if (idx < 5) return 3'd2;
        else if (idx < 8) return 3'd3;
        else              return 3'd4;
    endfunction

    always @(negedge clk) begin
        if (val_enable === 1'b1 && prev_ve !== 1'b1) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_val_enable", val_enable, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_x1", x1, e.x);
                chk("sb_y1", y1, e.y);
                chk("sb_dir", direcao, e.d);
                chk("sb_ori", orientacao, e.o);
                chk("sb_tipo", tipo, e.t);
                chk("sb_jog", jogador, e.j);
                chk("sb_idx", navio_idx, e.idx);
            end
        end
        prev_ve = val_enable;
    end

    task automatic wait_estado(input int target, input int budget, input string tag);
        int i = 0;
        while (estado !== 3'(target) && i < budget) begin
            @(negedge clk);
            i++;
        end
        chk(tag, estado, target);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_val"}, val_enable, 0);
        chk({tag, "_tipo"}, tipo, 0);
        chk({tag, "_dir"}, direcao, 0);
        chk({tag, "_ori"}, orientacao, 0);
        chk({tag, "_x1"}, x1, 0);
        chk({tag, "_y1"}, y1, 0);
        chk({tag, "_jog"}, jogador, 0);
        chk({tag, "_idx"}, navio_idx, 0);
        chk({tag, "_erro"}, erro, 0);
        chk({tag, "_erro_to"}, erro_timeout, 0);
        chk({tag, "_concl"}, concluido, 0);
        chk({tag, "_estado"}, estado, 0);
    endtask

    task automatic do_start();
        m_idx = 0; m_jog = 0; m_done = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_estado", estado, 1);
    endtask

    task automatic press(input logic [3:0] x, input logic [3:0] y, input logic d, input logic [2:0] o);
        exp_t e;
        wait_estado(1, 20, "press_wait_espera");
        x_in = x; y_in = y; direcao_in = d; orientacao_in = o;
        confirma = 1'b1;
        e.x = x; e.y = y; e.d = d; e.o = o;
        e.t = tipo_of(m_idx); e.j = m_jog[0]; e.idx = 4'(m_idx);
        sb.push_back(e);
        @(negedge clk);
        confirma = 1'b0;
        x_in = ~x; y_in = ~y; direcao_in = ~d; orientacao_in = ~o;
        chk("press_val_latency", val_enable, 1);
        chk("press_estado", estado, 2);
    endtask

    task automatic accept(input int pl);
        wrep1 = (pl == 0);
        wrep2 = (pl == 1);
        @(negedge clk);
        wrep1 = 1'b0; wrep2 = 1'b0;
        chk("acc_estado", estado, 3);
        chk("acc_val", val_enable, 0);
        if (m_idx < 10) m_idx++;
        else if (m_jog == 0) begin m_jog = 1; m_idx = 0; end
        else m_done = 1;
        if (m_done != 0) wait_estado(5, 5, "acc_wait_fim");
        else             wait_estado(1, 10, "acc_wait_espera");
        chk("acc_idx", navio_idx, m_idx);
        chk("acc_jog", jogador, m_jog);
        chk("acc_tipo", tipo, tipo_of(m_idx));
        chk("acc_erro", erro, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got time-limit expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_n = 1'b1; start = 1'b0; confirma = 1'b0;
        x_in = '0; y_in = '0; direcao_in = 1'b0; orientacao_in = '0;
        wrep1 = 1'b0; wrep2 = 1'b0; conflito_borda = 1'b0; conflito_memoria = 1'b0;
        #1 rst_n = 1'b0;
        @(negedge clk);
        check_zero("rst");
        rst_n = 1'b1;
        @(negedge clk);

        // 1: first placement with exact release timing
        do_start();
        press(4'd2, 4'd3, 1'b0, 3'd0);
        chk("t1_tipo", tipo, 0);
        chk("t1_x1", x1, 2);
        chk("t1_y1", y1, 3);
        @(negedge clk);
        wrep1 = 1'b1;
        @(negedge clk);
        wrep1 = 1'b0;
        chk("t1_aceita", estado, 3);
        m_idx = 1;
        @(negedge clk);
        chk("t1_pausa1", estado, 4);
        chk("t1_pausa1_val", val_enable, 0);
        chk("t1_idx", navio_idx, 1);
        chk("t1_tipo1", tipo, 1);
        @(negedge clk);
        chk("t1_pausa2", estado, 4);
        chk("t1_pausa2_val", val_enable, 0);
        @(negedge clk);
        chk("t1_espera", estado, 1);

        // 2: border conflict, then retry clears erro
        press(4'd9, 4'd9, 1'b1, 3'd1);
        conflito_borda = 1'b1;
        @(negedge clk);
        conflito_borda = 1'b0;
        chk("t2_rejeita", estado, 4);
        chk("t2_erro", erro, 1);
        wait_estado(1, 10, "t2_back_espera");
        chk("t2_erro_hold", erro, 1);
        chk("t2_idx", navio_idx, 1);
        press(4'd4, 4'd5, 1'b1, 3'd2);
        chk("t2_erro_clr", erro, 0);
        accept(0);

        // 3: timeout
        press(4'd6, 4'd7, 1'b0, 3'd3);
        n = 1;
        forever begin
            @(negedge clk);
            if (estado == 3'd2 && n < 100) n++;
            else break;
        end
        chk("t3_timeout_cycles", n, 64);
        chk("t3_estado", estado, 4);
        chk("t3_erro_to", erro_timeout, 1);
        chk("t3_erro", erro, 0);
        wait_estado(1, 10, "t3_back_espera");
        chk("t3_tipo", tipo, tipo_of(m_idx));
        chk("t3_idx", navio_idx, m_idx);

        // 4: rest of player 0, then other-player strobe ignored
        while (m_jog == 0) begin
            press(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                  1'($urandom_range(0, 1)), 3'($urandom_range(0, 3)));
            accept(0);
        end
        press(4'd1, 4'd1, 1'b0, 3'd0);
        wrep1 = 1'b1;
        @(negedge clk);
        wrep1 = 1'b0;
        chk("t4_wrep1_ignored", estado, 2);
        accept(1);

        // 5: finish player 1
        while (m_done == 0) begin
            press(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                  1'($urandom_range(0, 1)), 3'($urandom_range(0, 3)));
            accept(1);
        end
        chk("t5_concluido", concluido, 1);
        start = 1'b1; confirma = 1'b1;
        @(negedge clk);
        confirma = 1'b0;
        repeat (5) @(negedge clk);
        start = 1'b0;
        chk("t5_stay_fim", estado, 5);
        chk("t5_val", val_enable, 0);
        chk("t5_idx", navio_idx, 10);
        chk("t5_jog", jogador, 1);

        // 6: async reset mid-AGUARDA, then strobe+conflict together
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_start();
        press(4'd8, 4'd2, 1'b1, 3'd1);
        #2 rst_n = 1'b0;
        #1 check_zero("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_start();
        press(4'd3, 4'd4, 1'b0, 3'd2);
        conflito_memoria = 1'b1;
        accept(0);
        conflito_memoria = 1'b0;
        chk("t6_erro", erro, 0);

        repeat (3) @(negedge clk);
        chk("sb_leftover", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/controle_posicionamento.md
Name: controle_posicionamento

Overview:
Placement-phase sequencer for the naval-battle board. It walks each player through the fixed fleet, one ship at a time. For each ship it latches the player's coordinates on a confirm press, drives the piece validator, and waits for a write strobe or a conflict. It then advances to the next ship or rejects the attempt. It sits between the input/debounce logic and the validator, and owns the player and ship-index state until both fleets are placed.

Parameters:
NUM_NAVIOS, 11, ships per player; fleet order is fixed (see Behaviour).
TIMEOUT, 64, max cycles in AGUARDA before forced reject.
RELEASE, 2, cycles val_enable stays low after a result, before a new confirm is accepted.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  level; begin placement phase from OCIOSO
confirma  in  1  debounced level; rising edge = submit placement
x_in  in  4  column from switches
y_in  in  4  row from switches
direcao_in  in  1  0 horizontal, 1 vertical
orientacao_in  in  3  hidroaviao orientation 0..3
wrep1  in  1  validator write strobe, player 0
wrep2  in  1  validator write strobe, player 1
conflito_borda  in  1  validator border conflict
conflito_memoria  in  1  validator memory conflict
val_enable  out  1  validator enable
tipo  out  3  ship type to validator
direcao  out  1  latched direction
orientacao  out  3  latched orientation
x1  out  4  latched x
y1  out  4  latched y
jogador  out  1  current player
navio_idx  out  4  index of ship being placed, 0..NUM_NAVIOS-1
erro  out  1  last attempt rejected (border or memory conflict)
erro_timeout  out  1  last attempt rejected by timeout
concluido  out  1  both fleets placed
estado  out  3  FSM state, debug/LED

Behaviour:
- Reset (async, rst_n=0): state OCIOSO; all outputs 0; the edge-detect register for confirma is cleared. A reset mid-validation drops val_enable in the same instant.
- Fleet order by navio_idx:
  - 0 → tipo 0 (porta-avioes)
  - 1–2 → tipo 1 (encouracado)
  - 3–4 → tipo 2 (hidroaviao)
  - 5–7 → tipo 3 (cruzador)
  - 8–10 → tipo 4 (submarino)
  - tipo is combinational from navio_idx.
- Confirm edge: conf_q registers confirma each cycle; a press is confirma & ~conf_q. It is honoured only in ESPERA; edges in any other state are dropped and do not queue.
- States (estado encoding 0..5):
  - OCIOSO(0): start=1 → ESPERA; jogador=0, navio_idx=0.
  - ESPERA(1): on press, latch x_in/y_in/direcao_in/orientacao_in into x1/y1/direcao/orientacao. Clear erro and erro_timeout, set val_enable=1, go to AGUARDA. Latency: press to val_enable high is 1 cycle.
  - AGUARDA(2): val_enable held at 1; the cycle counter increments each cycle. Priority each cycle:
    - The write strobe for the current jogador (wrep1 if jogador=0, wrep2 if jogador=1) → ACEITA.
    - Otherwise, conflito_borda or conflito_memoria → REJEITA, erro=1.
    - Otherwise, counter == TIMEOUT-1 → REJEITA, erro_timeout=1.
    - A strobe for the other player is ignored.
    - A strobe and a conflict in the same cycle resolve as accept.
  - ACEITA(3): val_enable=0.
    - If navio_idx < NUM_NAVIOS-1: navio_idx+1, then PAUSA.
    - Else if jogador=0: jogador=1, navio_idx=0, then PAUSA.
    - Else: go to FIM.
  - REJEITA(4): val_enable=0; navio_idx and jogador unchanged; → PAUSA. erro/erro_timeout hold until the next accepted press.
  - PAUSA: shares encoding 4 with REJEITA on estado. Counts RELEASE cycles with val_enable=0, then → ESPERA. This guarantees a fresh rising edge on the validator enable.
  - FIM(5): concluido=1, val_enable=0; stays until reset. start is ignored here.
- The AGUARDA counter is 7 bits wide and cleared on AGUARDA entry. Width must cover TIMEOUT.
- navio_idx never exceeds NUM_NAVIOS-1; there is no wrap within a player.
- x1/y1/direcao/orientacao hold their values outside ESPERA; switch changes during AGUARDA have no effect.
- Total accepted placements before concluido = 2*NUM_NAVIOS = 22.

Test Plan:
1. Reset then start=1, press with x=2,y=3,dir=0: val_enable=1 one cycle after the press, tipo=0, x1=2, y1=3. Drive wrep1 3 cycles later → navio_idx=1, tipo=1, val_enable=0 for 2 cycles, estado=1.
2. In AGUARDA, assert conflito_borda → erro=1, navio_idx unchanged. Next press clears erro; wrep1 then advances navio_idx.
3. No validator response for 64 cycles → erro_timeout=1, estado returns to 1 after RELEASE; tipo unchanged.
4. Accept 11 ships for player 0 → jogador=1, navio_idx=0, tipo=0. wrep1 pulses during player 1 AGUARDA are ignored; wrep2 is accepted.
5. Accept all 22 placements → concluido=1, estado=5. Further presses and start have no effect.
6. Pull rst_n low in mid-AGUARDA (asynchronous, between clock edges) → val_enable=0 immediately, all outputs 0. wrep1 and conflito_memoria asserted together in one cycle → accept, erro stays 0.
